// File: rtl/snoop_arbiter.sv
// Shares one cache snoop port between NumReq coherency managers and routes CR/CD back in AC issue order.
// Define SNOOP_ARB_RR_EN for round-robin AC arbitration; otherwise the lowest requesting index wins.
module snoop_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq*AddrWidth-1:0]    slv_ac_addr_i,
    input  logic [NumReq*3-1:0]            slv_ac_acprot_i,
    input  logic [NumReq*4-1:0]            slv_ac_acsnoop_i,
    input  logic [NumReq-1:0]              slv_ac_valid_i,
    output logic [NumReq-1:0]              slv_ac_ready_o,
    output logic [NumReq*5-1:0]            slv_cr_resp_o,
    output logic [NumReq-1:0]              slv_cr_valid_o,
    input  logic [NumReq-1:0]              slv_cr_ready_i,
    output logic [NumReq*DataWidth-1:0]    slv_cd_data_o,
    output logic [NumReq-1:0]              slv_cd_last_o,
    output logic [NumReq-1:0]              slv_cd_valid_o,
    input  logic [NumReq-1:0]              slv_cd_ready_i,
    output logic [AddrWidth-1:0]           mst_ac_addr_o,
    output logic [2:0]                     mst_ac_acprot_o,
    output logic [3:0]                     mst_ac_acsnoop_o,
    output logic                           mst_ac_valid_o,
    input  logic                           mst_ac_ready_i,
    input  logic [4:0]                     mst_cr_resp_i,
    input  logic                           mst_cr_valid_i,
    output logic                           mst_cr_ready_o,
    input  logic [DataWidth-1:0]           mst_cd_data_i,
    input  logic                           mst_cd_last_i,
    input  logic                           mst_cd_valid_i,
    output logic                           mst_cd_ready_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? PtrW'(0) : p + PtrW'(1);
    endfunction

    logic [IdxW-1:0] cr_mem_r [MaxTrans];
    logic [IdxW-1:0] cd_mem_r [MaxTrans];
    logic [PtrW-1:0] cr_wr_ptr_r, cr_rd_ptr_r, cd_wr_ptr_r, cd_rd_ptr_r;
    logic [CntW-1:0] cr_cnt_r, cd_cnt_r;
    logic            lock_r;
    logic [IdxW-1:0] lock_idx_r;
`ifdef SNOOP_ARB_RR_EN
    logic [IdxW-1:0] rr_ptr_r;
`endif

    logic [IdxW-1:0] arb_idx_s, cand_s, win_s, cr_head_s, cd_head_s;
    logic            cr_full_s, cr_empty_s, cd_full_s, cd_empty_s;
    logic            ac_hs_s, cr_hs_s, cd_push_s, cd_pop_s;

    // Full/empty come from registered counts only, so a same-cycle pop never frees a slot.
    assign cr_full_s  = (cr_cnt_r == CntW'(MaxTrans));
    assign cr_empty_s = (cr_cnt_r == CntW'(0));
    assign cd_full_s  = (cd_cnt_r == CntW'(MaxTrans));
    assign cd_empty_s = (cd_cnt_r == CntW'(0));
    assign cr_head_s  = cr_mem_r[cr_rd_ptr_r];
    assign cd_head_s  = cd_mem_r[cd_rd_ptr_r];

    // Pick the AC winner; a stalled grant is held by the lock until its handshake.
    always_comb begin
        arb_idx_s = '0;
        cand_s    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
`ifdef SNOOP_ARB_RR_EN
            cand_s = IdxW'((32'(rr_ptr_r) + 32'(i)) % NumReq);
`else
            cand_s = IdxW'(i);
`endif
            arb_idx_s = slv_ac_valid_i[cand_s] ? cand_s : arb_idx_s;
        end
        win_s = lock_r ? lock_idx_r : arb_idx_s;
    end

    assign mst_ac_valid_o   = rst_ni & (|slv_ac_valid_i) & ~cr_full_s;
    assign ac_hs_s          = mst_ac_valid_o & mst_ac_ready_i;
    assign mst_ac_addr_o    = slv_ac_addr_i[32'(win_s)*AddrWidth +: AddrWidth];
    assign mst_ac_acprot_o  = slv_ac_acprot_i[32'(win_s)*3 +: 3];
    assign mst_ac_acsnoop_o = slv_ac_acsnoop_i[32'(win_s)*4 +: 4];

    assign mst_cr_ready_o = rst_ni & ~cr_empty_s & slv_cr_ready_i[cr_head_s]
                          & (~mst_cr_resp_i[0] | ~cd_full_s);
    assign cr_hs_s        = mst_cr_valid_i & mst_cr_ready_o;
    assign cd_push_s      = cr_hs_s & mst_cr_resp_i[0];
    assign mst_cd_ready_o = rst_ni & ~cd_empty_s & slv_cd_ready_i[cd_head_s];
    assign cd_pop_s       = mst_cd_valid_i & mst_cd_ready_o & mst_cd_last_i;

    assign slv_cr_resp_o = {NumReq{mst_cr_resp_i}};
    assign slv_cd_data_o = {NumReq{mst_cd_data_i}};
    assign slv_cd_last_o = {NumReq{mst_cd_last_i}};

    // Steer ready/valid one-hot to the granted AC initiator and the CR/CD FIFO heads.
    always_comb begin
        slv_ac_ready_o = '0;
        slv_cr_valid_o = '0;
        slv_cd_valid_o = '0;
        if (ac_hs_s) begin
            slv_ac_ready_o[win_s] = 1'b1;
        end else begin
            slv_ac_ready_o = '0;
        end
        if (rst_ni && mst_cr_valid_i && !cr_empty_s) begin
            slv_cr_valid_o[cr_head_s] = 1'b1;
        end else begin
            slv_cr_valid_o = '0;
        end
        if (rst_ni && mst_cd_valid_i && !cd_empty_s) begin
            slv_cd_valid_o[cd_head_s] = 1'b1;
        end else begin
            slv_cd_valid_o = '0;
        end
    end

    // Index FIFO of granted initiators awaiting their CR response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cr_mem_r    <= '{default: '0};
            cr_wr_ptr_r <= '0;
            cr_rd_ptr_r <= '0;
            cr_cnt_r    <= '0;
        end else begin
            if (ac_hs_s) begin
                cr_mem_r[cr_wr_ptr_r] <= win_s;
                cr_wr_ptr_r           <= ptr_inc(cr_wr_ptr_r);
            end
            if (cr_hs_s) begin
                cr_rd_ptr_r <= ptr_inc(cr_rd_ptr_r);
            end
            case ({ac_hs_s, cr_hs_s})
                2'b10:   cr_cnt_r <= cr_cnt_r + CntW'(1);
                2'b01:   cr_cnt_r <= cr_cnt_r - CntW'(1);
                default: cr_cnt_r <= cr_cnt_r;
            endcase
        end
    end

    // Index FIFO of DataTransfer responses awaiting their CD burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cd_mem_r    <= '{default: '0};
            cd_wr_ptr_r <= '0;
            cd_rd_ptr_r <= '0;
            cd_cnt_r    <= '0;
        end else begin
            if (cd_push_s) begin
                cd_mem_r[cd_wr_ptr_r] <= cr_head_s;
                cd_wr_ptr_r           <= ptr_inc(cd_wr_ptr_r);
            end
            if (cd_pop_s) begin
                cd_rd_ptr_r <= ptr_inc(cd_rd_ptr_r);
            end
            case ({cd_push_s, cd_pop_s})
                2'b10:   cd_cnt_r <= cd_cnt_r + CntW'(1);
                2'b01:   cd_cnt_r <= cd_cnt_r - CntW'(1);
                default: cd_cnt_r <= cd_cnt_r;
            endcase
        end
    end

    // Grant lock for AC stability and the round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
`ifdef SNOOP_ARB_RR_EN
            rr_ptr_r   <= '0;
`endif
        end else if (ac_hs_s) begin
            lock_r     <= 1'b0;
`ifdef SNOOP_ARB_RR_EN
            rr_ptr_r   <= IdxW'((32'(win_s) + 32'd1) % NumReq);
`endif
        end else if (mst_ac_valid_o) begin
            lock_r     <= 1'b1;
            lock_idx_r <= win_s;
        end else begin
            lock_r     <= lock_r;
        end
    end

endmodule

// File: tb/tb_snoop_arbiter.sv
// Self-checking bench for snoop_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Honours SNOOP_ARB_RR_EN the same way as the design.
module tb_snoop_arbiter;

    localparam int NumReq = 2;
    localparam int AW     = 64;
    localparam int DW     = 64;
    localparam int MaxTr  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]          ac_addr [NumReq];
    logic [2:0]             ac_prot [NumReq];
    logic [3:0]             ac_snp  [NumReq];
    logic [NumReq*AW-1:0]   slv_ac_addr;
    logic [NumReq*3-1:0]    slv_ac_acprot;
    logic [NumReq*4-1:0]    slv_ac_acsnoop;
    logic [NumReq-1:0]      ac_valid = '0, slv_ac_ready;
    logic [NumReq*5-1:0]    slv_cr_resp;
    logic [NumReq-1:0]      slv_cr_valid, cr_ready = '0;
    logic [NumReq*DW-1:0]   slv_cd_data;
    logic [NumReq-1:0]      slv_cd_last, slv_cd_valid, cd_ready = '0;
    logic [AW-1:0]          mst_ac_addr;
    logic [2:0]             mst_ac_acprot;
    logic [3:0]             mst_ac_acsnoop;
    logic                   mst_ac_valid, mst_ac_ready = 1'b0;
    logic [4:0]             cr_resp = '0;
    logic                   cr_valid = 1'b0, mst_cr_ready;
    logic [DW-1:0]          cd_data = '0;
    logic                   cd_last = 1'b0, cd_valid = 1'b0, mst_cd_ready;

    for (genvar g = 0; g < NumReq; g++) begin : g_pack
        assign slv_ac_addr[g*AW +: AW]  = ac_addr[g];
        assign slv_ac_acprot[g*3 +: 3]  = ac_prot[g];
        assign slv_ac_acsnoop[g*4 +: 4] = ac_snp[g];
    end

    snoop_arbiter #(.NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MaxTr)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_ac_addr_i(slv_ac_addr), .slv_ac_acprot_i(slv_ac_acprot), .slv_ac_acsnoop_i(slv_ac_acsnoop),
        .slv_ac_valid_i(ac_valid), .slv_ac_ready_o(slv_ac_ready),
        .slv_cr_resp_o(slv_cr_resp), .slv_cr_valid_o(slv_cr_valid), .slv_cr_ready_i(cr_ready),
        .slv_cd_data_o(slv_cd_data), .slv_cd_last_o(slv_cd_last), .slv_cd_valid_o(slv_cd_valid),
        .slv_cd_ready_i(cd_ready),
        .mst_ac_addr_o(mst_ac_addr), .mst_ac_acprot_o(mst_ac_acprot), .mst_ac_acsnoop_o(mst_ac_acsnoop),
        .mst_ac_valid_o(mst_ac_valid), .mst_ac_ready_i(mst_ac_ready),
        .mst_cr_resp_i(cr_resp), .mst_cr_valid_i(cr_valid), .mst_cr_ready_o(mst_cr_ready),
        .mst_cd_data_i(cd_data), .mst_cd_last_i(cd_last), .mst_cd_valid_i(cd_valid),
        .mst_cd_ready_o(mst_cd_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: outstanding snoops as queues of initiator indices.
    int m_cr_q [$];
    int m_cd_q [$];
    int m_rr = 0;
    bit m_lock = 1'b0;
    int m_lock_idx = 0;
    bit m_acv, m_ac_hs, m_cr_hs, m_cr_dt, m_cd_pop;
    int m_win, m_cr_h;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_arb(input logic [NumReq-1:0] v);
        if (m_lock) return m_lock_idx;
        for (int k = 0; k < NumReq; k++) begin
`ifdef SNOOP_ARB_RR_EN
            int c = (m_rr + k) % NumReq;
`else
            int c = k;
`endif
            if (v[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_cr_q.delete();
        m_cd_q.delete();
        m_rr = 0;
        m_lock = 1'b0;
    endtask

    // Compare every DUT output against the model, away from the clock edge.
    task automatic settle();
        logic [NumReq-1:0] e_acr, e_crv, e_cdv;
        logic e_crr, e_cdr;
        #1;
        m_win   = model_arb(ac_valid);
        m_acv   = (ac_valid != '0) && (m_cr_q.size() < MaxTr);
        m_ac_hs = m_acv && mst_ac_ready;
        e_acr   = m_ac_hs ? (NumReq'(1) << m_win) : '0;
        check_eq("ac_valid", mst_ac_valid, m_acv);
        check_eq("ac_ready", slv_ac_ready, e_acr);
        if (m_acv) begin
            check_eq("ac_addr", mst_ac_addr, ac_addr[m_win]);
            check_eq("ac_prot", mst_ac_acprot, ac_prot[m_win]);
            check_eq("ac_snoop", mst_ac_acsnoop, ac_snp[m_win]);
        end
        e_crv = '0; e_crr = 1'b0; m_cr_h = 0;
        if (m_cr_q.size() > 0) begin
            m_cr_h = m_cr_q[0];
            e_crv  = cr_valid ? (NumReq'(1) << m_cr_h) : '0;
            e_crr  = cr_ready[m_cr_h] && (!cr_resp[0] || m_cd_q.size() < MaxTr);
        end
        m_cr_hs = cr_valid && e_crr;
        m_cr_dt = cr_resp[0];
        check_eq("cr_valid", slv_cr_valid, e_crv);
        check_eq("cr_ready", mst_cr_ready, e_crr);
        check_eq("cr_resp", slv_cr_resp, {NumReq{cr_resp}});
        e_cdv = '0; e_cdr = 1'b0;
        if (m_cd_q.size() > 0) begin
            e_cdv = cd_valid ? (NumReq'(1) << m_cd_q[0]) : '0;
            e_cdr = cd_ready[m_cd_q[0]];
        end
        m_cd_pop = cd_valid && e_cdr && cd_last;
        check_eq("cd_valid", slv_cd_valid, e_cdv);
        check_eq("cd_ready", mst_cd_ready, e_cdr);
        check_eq("cd_data", slv_cd_data, {NumReq{cd_data}});
        check_eq("cd_last", slv_cd_last, {NumReq{cd_last}});
    endtask

    // Advance the model at the clock edge; handshaken initiators drop valid at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (m_cd_pop) void'(m_cd_q.pop_front());
        if (m_cr_hs) begin
            void'(m_cr_q.pop_front());
            if (m_cr_dt) m_cd_q.push_back(m_cr_h);
        end
        if (m_ac_hs) begin
            m_cr_q.push_back(m_win);
            m_lock = 1'b0;
            m_rr   = (m_win + 1) % NumReq;
        end else if (m_acv) begin
            m_lock     = 1'b1;
            m_lock_idx = m_win;
        end
        @(negedge clk);
        if (m_ac_hs) ac_valid[m_win] = 1'b0;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_eq({tag, "_ac_valid"}, mst_ac_valid, 1'b0);
        check_eq({tag, "_ac_ready"}, slv_ac_ready, '0);
        check_eq({tag, "_cr_valid"}, slv_cr_valid, '0);
        check_eq({tag, "_cr_ready"}, mst_cr_ready, 1'b0);
        check_eq({tag, "_cd_valid"}, slv_cd_valid, '0);
        check_eq({tag, "_cd_ready"}, mst_cd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain_cr();
        ac_valid = '0; cr_valid = 1'b1; cr_resp = 5'h0; cr_ready = '1;
        for (int i = 0; i < 16 && m_cr_q.size() != 0; i++) step();
        cr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NumReq-1:0] exp_g;
        int seq [3];
        for (int i = 0; i < NumReq; i++) begin
            ac_addr[i] = '0; ac_prot[i] = '0; ac_snp[i] = '0;
        end
        @(negedge clk);
        ac_valid = '1; mst_ac_ready = 1'b1; cr_valid = 1'b1; cr_ready = '1;
        cd_valid = 1'b1; cd_ready = '1;
        do_reset("reset");
        ac_valid = '0; cd_valid = 1'b0; mst_ac_ready = 1'b0;

        // CR with no outstanding AC must stall.
        cr_valid = 1'b1; cr_resp = 5'h1;
        settle();
        check_eq("stall_cr_ready", mst_cr_ready, 1'b0);
        tick();
        cr_valid = 1'b0;

        // T1: single snoop from req1 with a two-beat data burst.
        ac_valid = 2'b10; ac_addr[1] = 64'h1000; ac_snp[1] = 4'h1; ac_prot[1] = 3'h0; mst_ac_ready = 1'b1;
        settle();
        check_eq("t1_addr", mst_ac_addr, 64'h1000);
        check_eq("t1_ac_ready", slv_ac_ready, 2'b10);
        tick();
        cr_valid = 1'b1; cr_resp = 5'b00001;
        settle();
        check_eq("t1_cr_valid", slv_cr_valid, 2'b10);
        tick();
        cr_valid = 1'b0; cd_valid = 1'b1; cd_data = 64'hA; cd_last = 1'b0;
        settle();
        check_eq("t1_cd_beat1", slv_cd_valid, 2'b10);
        tick();
        cd_data = 64'hB; cd_last = 1'b1;
        settle();
        check_eq("t1_cd_beat2", slv_cd_valid, 2'b10);
        check_eq("t1_cd_last", slv_cd_last, 2'b11);
        tick();
        cd_valid = 1'b0; cd_last = 1'b0;

        // T2: both initiators requesting every cycle.
        for (int g = 0; g < 4; g++) begin
            ac_valid = 2'b11; ac_addr[0] = 64'h2000 + 64'(g); ac_addr[1] = 64'h2100 + 64'(g);
`ifdef SNOOP_ARB_RR_EN
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            settle();
            check_eq("t2_grant", slv_ac_ready, exp_g);
            tick();
        end

        // T4: cr_fifo now full; a CR pop does not free the slot in the same cycle.
        ac_valid = 2'b01;
        settle();
        check_eq("t4_full_valid", mst_ac_valid, 1'b0);
        check_eq("t4_full_ready", slv_ac_ready, 2'b00);
        tick();
        cr_valid = 1'b1; cr_resp = 5'h0;
        settle();
        check_eq("t4_pop_cycle_valid", mst_ac_valid, 1'b0);
        check_eq("t4_cr_ready", mst_cr_ready, 1'b1);
        tick();
        cr_valid = 1'b0;
        settle();
        check_eq("t4_next_accept", slv_ac_ready, 2'b01);
        tick();
        drain_cr();

        // T3: stalled grant to req1 must hold while req0 arrives.
        mst_ac_ready = 1'b0; ac_valid = 2'b10; ac_addr[1] = 64'h3333; ac_addr[0] = 64'h4444;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ac_valid[0] = 1'b1;
            settle();
            check_eq("t3_addr_hold", mst_ac_addr, 64'h3333);
            tick();
        end
        mst_ac_ready = 1'b1;
        settle();
        check_eq("t3_first_grant", slv_ac_ready, 2'b10);
        tick();
        settle();
        check_eq("t3_second_grant", slv_ac_ready, 2'b01);
        tick();
        drain_cr();

        // T5: in-order CRs, only the DataTransfer one queues a CD burst.
        seq = '{0, 1, 0};
        for (int k = 0; k < 3; k++) begin
            ac_valid = NumReq'(1) << seq[k];
            settle();
            check_eq("t5_ac_grant", slv_ac_ready, NumReq'(1) << seq[k]);
            tick();
        end
        cr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cr_resp = (k == 1) ? 5'h1 : 5'h0;
            settle();
            check_eq("t5_cr_route", slv_cr_valid, NumReq'(1) << seq[k]);
            tick();
        end
        cr_valid = 1'b0; cd_valid = 1'b1; cd_last = 1'b1; cd_data = 64'h55;
        settle();
        check_eq("t5_cd_route", slv_cd_valid, 2'b10);
        tick();
        settle();
        check_eq("t5_cd_empty", slv_cd_valid, 2'b00);
        tick();
        cd_valid = 1'b0;

        // T6: reset in the middle of a CD burst.
        ac_valid = 2'b10;
        step();
        cr_valid = 1'b1; cr_resp = 5'h1;
        step();
        cr_valid = 1'b0; cd_valid = 1'b1; cd_last = 1'b0;
        step();
        cd_last = 1'b1; ac_valid = 2'b11; cr_valid = 1'b1;
        do_reset("t6_rst");
        ac_valid = '0;
        settle();
        check_eq("t6_cd_after", slv_cd_valid, 2'b00);
        check_eq("t6_cr_after", slv_cr_valid, 2'b00);
        tick();

        // Randomized traffic with AXI-stable initiators.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!ac_valid[i] && $urandom_range(0, 99) < 40) begin
                    ac_valid[i] = 1'b1;
                    ac_addr[i]  = {$urandom, $urandom};
                    ac_prot[i]  = 3'($urandom);
                    ac_snp[i]   = 4'($urandom);
                end
            end
            mst_ac_ready = ($urandom_range(0, 99) < 60);
            cr_valid     = 1'($urandom);
            cr_resp      = 5'($urandom);
            cr_ready     = NumReq'($urandom);
            cd_valid     = 1'($urandom);
            cd_data      = {$urandom, $urandom};
            cd_last      = ($urandom_range(0, 99) < 40);
            cd_ready     = NumReq'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
